// File: rtl/multi_push_packer.sv
// multi_push_packer
//   Upstream feeder for the multi-push sync FIFO. Takes a group of up to M
//   sparse-valid lanes per handshake, compacts the valid lanes (lowest lane
//   first) into the FIFO's dense, thermometer-coded push vector, and never
//   pushes more entries than the FIFO reports as free. Lanes that do not fit
//   are parked in a hold buffer and drained, in order, on later cycles.
//
// Configuration macro:
//   MULTI_PUSH_PACKER_BYPASS_EN
//     defined   : an accepted group may push in its accept cycle.
//     undefined : push/datain come only from the hold registers. Every group
//                 sits in hold for at least one cycle.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   in_valid      per-lane valid of the offered group (may be sparse)
//   in_data       per-lane payload
//   in_ready      group accepted when in_ready & |in_valid
//   clear         synchronous flush of the hold buffer
//   push          FIFO push vector, thermometer coded
//   datain        FIFO push data, slot k = k-th oldest pending lane
//   full          FIFO full flag
//   almost_full   FIFO almost-full flags, bit i means free slots <= i
//   pending_cnt   number of entries currently in the hold buffer
module multi_push_packer #(
  parameter type T = logic [7:0],
  parameter int  M = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [M-1:0]           in_valid,
  input  T                       in_data [M],
  output logic                   in_ready,
  input  logic                   clear,
  output logic [M-1:0]           push,
  output T                       datain [M],
  input  logic                   full,
  input  logic [M-1:1]           almost_full,
  output logic [$clog2(M+1)-1:0] pending_cnt
);

  localparam int CW = $clog2(M+1);

  // Registered state
  logic          ready_q;
  logic [CW-1:0] hold_cnt;
  T              hold [M];

  // Combinational intermediates
  logic [CW-1:0] free;
  logic          fire;
  logic [CW-1:0] grp_cnt;
  T              grp [M];
  logic [CW-1:0] cand_cnt;
  T              cand [M];
  logic [CW-1:0] n;
  logic [CW-1:0] hold_cnt_next;
  T              hold_next [M];

  // in_ready depends only on registered state plus clear; the FIFO flags
  // never feed it, so there is no combinational loop back through the FIFO.
  assign in_ready    = ready_q & (hold_cnt == '0) & ~clear;
  assign fire        = in_ready & (|in_valid);
  assign pending_cnt = hold_cnt;

  // Free slots: the lowest asserted almost_full bit is the tightest bound,
  // so scan downward and let the smallest index win.
  always_comb begin
    free = CW'(M);
    if (full) begin
      free = '0;
    end else begin
      for (int i = M-1; i >= 1; i--) begin
        if (almost_full[i]) free = CW'(i);
      end
    end
  end

  // Compact the valid lanes of the offered group into grp[0..grp_cnt-1];
  // unused slots are zero so later shifts never pull in stale payload.
  always_comb begin
    grp_cnt = '0;
    for (int k = 0; k < M; k++) grp[k] = '0;
    for (int k = 0; k < M; k++) begin
      if (in_valid[k]) begin
        for (int j = 0; j < M; j++) begin
          if (grp_cnt == CW'(j)) grp[j] = in_data[k];
        end
        grp_cnt = grp_cnt + CW'(1);
      end
    end
  end

  // Candidate entries for this cycle's push. The hold buffer always has
  // priority; with bypass enabled an empty hold lets a freshly accepted
  // group go straight to the FIFO.
  always_comb begin
    cand_cnt = hold_cnt;
    for (int k = 0; k < M; k++) cand[k] = hold[k];
`ifdef MULTI_PUSH_PACKER_BYPASS_EN
    if (hold_cnt == '0) begin
      cand_cnt = fire ? grp_cnt : '0;
      for (int k = 0; k < M; k++) cand[k] = fire ? grp[k] : '0;
    end
`endif
  end

  // Push count: limited by free space; a clear cycle pushes nothing so it
  // cannot race the FIFO's own flush.
  always_comb begin
    if (clear) begin
      n = '0;
    end else if (cand_cnt < free) begin
      n = cand_cnt;
    end else begin
      n = free;
    end
  end

  // Thermometer push vector and data; slots beyond the push count read zero.
  always_comb begin
    for (int k = 0; k < M; k++) begin
      push[k]   = (CW'(k) < n);
      datain[k] = (CW'(k) < n) ? cand[k] : '0;
    end
  end

  // Next hold contents: the unpushed tail of the candidates slides down to
  // slot 0, keeping arrival order. Without bypass, an accepted group is
  // parked whole (hold is empty whenever a group can fire).
  always_comb begin
    hold_cnt_next = cand_cnt - n;
    for (int k = 0; k < M; k++) begin
      hold_next[k] = '0;
      for (int j = 0; j < M; j++) begin
        if (int'(n) + k == j) hold_next[k] = cand[j];
      end
    end
`ifndef MULTI_PUSH_PACKER_BYPASS_EN
    if (fire) begin
      hold_cnt_next = grp_cnt;
      for (int k = 0; k < M; k++) hold_next[k] = grp[k];
    end
`endif
    if (clear) begin
      hold_cnt_next = '0;
      for (int k = 0; k < M; k++) hold_next[k] = '0;
    end
  end

  // State registers. ready_q holds in_ready low until the first edge after
  // reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q  <= 1'b0;
      hold_cnt <= '0;
      for (int k = 0; k < M; k++) hold[k] <= '0;
    end else begin
      ready_q  <= 1'b1;
      hold_cnt <= hold_cnt_next;
      for (int k = 0; k < M; k++) hold[k] <= hold_next[k];
    end
  end

endmodule
